// File: rtl/test_card_sequencer.sv
// Frame-synchronous test card scheduler: picks one of PATTERNS RGB sources,
// advancing on a frame count or a user request, only at start-of-frame.
module test_card_sequencer #(
  parameter  int PATTERNS           = 4,
  parameter  int FRAMES_PER_PATTERN = 120,
  localparam int SW                 = $clog2(PATTERNS)
) (
  input  logic                   i_pix_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame,
  input  logic                   i_de,
  input  logic                   i_next,
  input  logic                   i_hold,
  input  logic [PATTERNS*24-1:0] i_rgb,
  output logic [SW-1:0]          o_sel,
  output logic                   o_switch,
  output logic                   o_de,
  output logic [7:0]             o_red,
  output logic [7:0]             o_green,
  output logic [7:0]             o_blue
);

  localparam int FW = $clog2(FRAMES_PER_PATTERN) + 1;
  localparam logic [FW-1:0] LAST_F   = FW'(FRAMES_PER_PATTERN - 1);
  localparam logic [SW-1:0] LAST_SEL = SW'(PATTERNS - 1);

  typedef enum logic {
    AUTO = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic [SW-1:0] sel_d;
  logic          switch_d;
  logic          auto_fire;
  logic          adv;
  logic [23:0]   pix_d;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= AUTO;
      fcnt_q   <= '0;
      pend_q   <= 1'b0;
      o_sel    <= '0;
      o_switch <= 1'b0;
      o_de     <= 1'b0;
      o_red    <= '0;
      o_green  <= '0;
      o_blue   <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      pend_q   <= pend_d;
      o_sel    <= sel_d;
      o_switch <= switch_d;
      o_de     <= i_de;
      {o_red, o_green, o_blue} <= pix_d;
    end
  end

  always_comb begin
    state_d   = i_hold ? HELD : AUTO;
    fcnt_d    = fcnt_q;
    pend_d    = pend_q;
    sel_d     = o_sel;
    switch_d  = 1'b0;
    auto_fire = i_frame && (state_q == AUTO) && (fcnt_q == LAST_F);
    adv       = i_frame && (pend_q || auto_fire);

    if (adv) begin
      sel_d    = (o_sel == LAST_SEL) ? '0 : o_sel + SW'(1);
      fcnt_d   = '0;
      pend_d   = 1'b0;
      switch_d = 1'b1;
    end else if (i_frame && (state_q == AUTO)) begin
      fcnt_d = fcnt_q + FW'(1);
    end

    // A request arriving on the advancing frame is kept for the next frame.
    if (i_next) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    pix_d = '0;
    for (int unsigned k = 0; k < PATTERNS; k++) begin
      if (o_sel == SW'(k)) begin
        pix_d = i_rgb[24*k +: 24];
      end
    end
    if (!i_de) begin
      pix_d = '0;
    end
  end

endmodule
